// File: rtl/serial_parity_checker_pkg.sv
// Shared constants for the serial parity receiver: FSM encoding and idle line level.
// Pure definitions; no latency, no backpressure.
package serial_parity_checker_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial line in / reassembled word out bundle between link and receiver.
// Master drives the line and observes the word; slave is the receiver.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
) ();
    logic              din;
    logic              din_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output din, din_valid,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  din, din_valid,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/XorGate.sv
// Two-input XOR primitive.
// Combinational, zero latency, no backpressure.
module XorGate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

// File: rtl/parity_accum.sv
// 1-bit running-XOR register: load sets an initial value, enable folds one bit in.
// One cycle from enable to updated acc_o; holds when neither load nor enable.
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic init_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);
    logic acc_q;
    logic acc_d;
    logic xor_y;

    XorGate u_xor (
        .a_i (acc_q),
        .b_i (bit_i),
        .y_o (xor_y)
    );

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = init_i;
        end else if (en_i) begin
            acc_d = xor_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: start, DATA_W data bits LSB first, parity, stop -> word + error flags.
// Word and flags appear one cycle after the stop beat; din_valid low freezes all state.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_parity_checker_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q,      state_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q,  frame_err_d;
    logic              busy_q,       busy_d;

    logic acc_load;
    logic acc_en;
    logic acc;
    logic beat;

    assign beat = bus.din_valid;

    parity_accum u_parity_accum (
        .clk    (clk),
        .rst    (rst),
        .load_i (acc_load),
        .init_i (ODD),
        .en_i   (acc_en),
        .bit_i  (bus.din),
        .acc_o  (acc)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        acc_load     = 1'b0;
        acc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat && (bus.din != LINE_IDLE)) begin
                    shift_d  = '0;
                    cnt_d    = '0;
                    acc_load = 1'b1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    // First data bit migrates down to bit 0 after DATA_W shifts.
                    shift_d = {bus.din, shift_q[DATA_W-1:1]};
                    acc_en  = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_d == CNT_LAST) begin
                        state_d = ST_PAR;
                    end
                end
            end
            ST_PAR: begin
                if (beat) begin
                    acc_en  = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (beat) begin
                    data_out_d   = shift_q;
                    parity_err_d = acc;
                    frame_err_d  = ~bus.din;
                    data_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
endmodule
